// File: rtl/sppf_pkg.sv
// Shared types and encodings for the SPPF stage sequencer.
package sppf_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CV1   = 3'd1,
    POOL1 = 3'd2,
    POOL2 = 3'd3,
    POOL3 = 3'd4,
    CV2   = 3'd5,
    ERR   = 3'd6
  } sppf_state_e;

  localparam logic [1:0] SLOT_CV1 = 2'd0;
  localparam logic [1:0] SLOT_Y1  = 2'd1;
  localparam logic [1:0] SLOT_Y2  = 2'd2;
  localparam logic [1:0] SLOT_Y3  = 2'd3;

  localparam logic [1:0] SRC_CV1 = 2'd0;
  localparam logic [1:0] SRC_Y1  = 2'd1;
  localparam logic [1:0] SRC_Y2  = 2'd2;

  // Buffer feeding the shared maxpool engine; a pure function of state so it
  // cannot move while a pool pass is running.
  function automatic logic [1:0] pool_src(input sppf_state_e s);
    case (s)
      POOL2:   return SRC_Y1;
      POOL3:   return SRC_Y2;
      default: return SRC_CV1;
    endcase
  endfunction

endpackage

// File: rtl/sppf_seq_ctrl_stage_timer.sv
// Per-stage watchdog shared by all engine stages: counts cycles since stage entry.
module stage_timer #(
  parameter int LIMIT = 4096,
  parameter int W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && (cnt != '1))
      cnt <= cnt + W'(1);
  end

  // cnt is 0 in the first stage cycle, so this fires in the LIMIT-th cycle.
  assign expire = (LIMIT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/sppf_seq_ctrl.sv
// SPPF sequencer: cv1 -> pool x3 -> cv2 with concat-slot commits.
// Optional build macro SPPF_SEQ_PERF_EN adds the perf_cycles counter.
//
// state | meaning
// IDLE  | waiting for start
// CV1   | cv1 1x1 conv running
// POOL1 | maxpool pass 1 (src cv1_out)
// POOL2 | maxpool pass 2 (src y1)
// POOL3 | maxpool pass 3 (src y2)
// CV2   | cv2 1x1 conv running
// ERR   | stage timed out, waiting for abort
module sppf_seq_ctrl
  import sppf_pkg::*;
#(
  parameter int STAGE_TIMEOUT = 4096,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       cv1_start,
  input  logic       cv1_done,
  output logic       pool_start,
  input  logic       pool_done,
  output logic [1:0] pool_src_sel,
  output logic       cv2_start,
  input  logic       cv2_done,
  output logic       cat_wr_en,
  output logic [1:0] cat_slot
`ifdef SPPF_SEQ_PERF_EN
  , output logic [CNT_W-1:0] perf_cycles
`endif
);

  sppf_state_e state, state_nxt;

  logic       cv1_start_nxt, pool_start_nxt, cv2_start_nxt;
  logic       wr_nxt, done_nxt, err_nxt;
  logic [1:0] slot_nxt;
  logic       in_stage, first, stage_done, fin, accept, expire;

  assign in_stage = state inside {CV1, POOL1, POOL2, POOL3, CV2};
  // The start pulse marks the first stage cycle, where done is not yet trusted.
  assign first    = cv1_start | pool_start | cv2_start;
  assign accept   = (state == IDLE) && start && !abort;

  always_comb begin
    stage_done = 1'b0;
    case (state)
      CV1:                 stage_done = cv1_done;
      POOL1, POOL2, POOL3: stage_done = pool_done;
      CV2:                 stage_done = cv2_done;
      default:             stage_done = 1'b0;
    endcase
  end

  assign fin = in_stage && stage_done && !first && !abort;

  stage_timer #(
    .LIMIT (STAGE_TIMEOUT),
    .W     (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (fin || accept),
    .en     (in_stage),
    .expire (expire)
  );

  always_comb begin
    state_nxt      = state;
    cv1_start_nxt  = 1'b0;
    pool_start_nxt = 1'b0;
    cv2_start_nxt  = 1'b0;
    wr_nxt         = 1'b0;
    done_nxt       = 1'b0;
    slot_nxt       = SLOT_CV1;
    err_nxt        = err;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt     = CV1;
          cv1_start_nxt = 1'b1;
          err_nxt       = 1'b0;
        end
      end
      ERR: begin
        if (abort) state_nxt = IDLE;
      end
      default: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (fin) begin
          wr_nxt = (state != CV2);
          case (state)
            CV1: begin
              state_nxt      = POOL1;
              pool_start_nxt = 1'b1;
              slot_nxt       = SLOT_CV1;
            end
            POOL1: begin
              state_nxt      = POOL2;
              pool_start_nxt = 1'b1;
              slot_nxt       = SLOT_Y1;
            end
            POOL2: begin
              state_nxt      = POOL3;
              pool_start_nxt = 1'b1;
              slot_nxt       = SLOT_Y2;
            end
            POOL3: begin
              state_nxt     = CV2;
              cv2_start_nxt = 1'b1;
              slot_nxt      = SLOT_Y3;
            end
            CV2: begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
          endcase
        end else if (expire) begin
          state_nxt = ERR;
          err_nxt   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cv1_start  <= 1'b0;
      pool_start <= 1'b0;
      cv2_start  <= 1'b0;
      cat_wr_en  <= 1'b0;
      cat_slot   <= SLOT_CV1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      cv1_start  <= cv1_start_nxt;
      pool_start <= pool_start_nxt;
      cv2_start  <= cv2_start_nxt;
      cat_wr_en  <= wr_nxt;
      cat_slot   <= slot_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
    end
  end

  assign busy         = (state != IDLE);
  assign pool_src_sel = pool_src(state);

`ifdef SPPF_SEQ_PERF_EN
  // Counts every busy cycle plus the done cycle, i.e. the full start-to-done latency.
  always_ff @(posedge clk) begin
    if (rst)
      perf_cycles <= '0;
    else if (accept)
      perf_cycles <= '0;
    else if ((busy || done) && (perf_cycles != '1))
      perf_cycles <= perf_cycles + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_sppf_seq_ctrl.sv
// Scoreboard bench for sppf_seq_ctrl: expected pulse events are queued by the
// stimulus and a negedge monitor pops/compares whenever the DUT emits a pulse.
module tb_sppf_seq_ctrl;

  localparam int TO = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic cv1_done = 1'b0, pool_done = 1'b0, cv2_done = 1'b0;
  logic busy, done, err, cv1_start, pool_start, cv2_start, cat_wr_en;
  logic [1:0] pool_src_sel, cat_slot;
`ifdef SPPF_SEQ_PERF_EN
  logic [CW-1:0] perf_cycles;
`endif

  sppf_seq_ctrl #(.STAGE_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .cv1_start(cv1_start), .cv1_done(cv1_done),
    .pool_start(pool_start), .pool_done(pool_done), .pool_src_sel(pool_src_sel),
    .cv2_start(cv2_start), .cv2_done(cv2_done),
    .cat_wr_en(cat_wr_en), .cat_slot(cat_slot)
`ifdef SPPF_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Engine done schedule: absolute cycle numbers at which each done is high.
  int cv1_q[$], pool_q[$], cv2_q[$];

  function automatic bit hit(input int q[$], input int c);
    foreach (q[i]) if (q[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    #1;
    cv1_done  = hit(cv1_q, cyc);
    pool_done = hit(pool_q, cyc);
    cv2_done  = hit(cv2_q, cyc);
  end

  // Event vector: {cv1_start, pool_start, cv2_start, cat_wr_en, done, src[1:0], slot[1:0]}
  typedef struct {
    int         c;
    logic [8:0] v;
  } ev_t;
  ev_t exp_q[$];

  function automatic void exp_ev(input int c, input logic cs, input logic ps,
                                 input logic c2s, input logic wr, input logic dn,
                                 input logic [1:0] src, input logic [1:0] slot);
    ev_t e;
    e.c = c;
    e.v = {cs, ps, c2s, wr, dn, src, slot};
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    ev_t        e;
    logic [8:0] v;
    if (!rst && (cv1_start || pool_start || cv2_start || cat_wr_en || done)) begin
      v = {cv1_start, pool_start, cv2_start, cat_wr_en, done, pool_src_sel, cat_slot};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got %b", cyc, v);
      end else begin
        e = exp_q.pop_front();
        if (e.c != cyc || e.v !== v) begin
          errors++;
          $display("FAIL event got cyc=%0d v=%b, expected cyc=%0d v=%b", cyc, v, e.c, e.v);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cyc=%0d)", n, a, e, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  // Every engine answers 3 cycles after its start pulse.
  task automatic plan_nominal(input int b);
    cv1_q.push_back(b + 4);
    pool_q.push_back(b + 8);
    pool_q.push_back(b + 12);
    pool_q.push_back(b + 16);
    cv2_q.push_back(b + 20);
    exp_ev(b + 1,  1, 0, 0, 0, 0, 2'd0, 2'd0);
    exp_ev(b + 5,  0, 1, 0, 1, 0, 2'd0, 2'd0);
    exp_ev(b + 9,  0, 1, 0, 1, 0, 2'd1, 2'd1);
    exp_ev(b + 13, 0, 1, 0, 1, 0, 2'd2, 2'd2);
    exp_ev(b + 17, 0, 0, 1, 1, 0, 2'd0, 2'd3);
    exp_ev(b + 21, 0, 0, 0, 0, 1, 2'd0, 2'd0);
  endtask

  initial begin
    int b, b2;

    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_starts", 32'({cv1_start, pool_start, cv2_start}), 0);
    chk("rst_cat", 32'({cat_wr_en, cat_slot}), 0);
    chk("rst_src", 32'(pool_src_sel), 0);
`ifdef SPPF_SEQ_PERF_EN
    chk("rst_perf", 32'(perf_cycles), 0);
`endif
    rst = 1'b0;
    tick();

    // Nominal run with stray dones from the wrong engine and in IDLE.
    b = cyc;
    plan_nominal(b);
    cv1_q.push_back(b + 6);
    cv2_q.push_back(b + 10);
    pool_q.push_back(b + 23);
    start = 1'b1; tick(); start = 1'b0;
    wait_cyc(b + 10); chk("nom_src_pool2", 32'(pool_src_sel), 1);
    wait_cyc(b + 20); chk("nom_busy_cv2", 32'(busy), 1);
    wait_cyc(b + 21); chk("nom_busy_done", 32'(busy), 0);
    wait_cyc(b + 22); chk("nom_busy_after", 32'(busy), 0);
    chk("nom_err", 32'(err), 0);
`ifdef SPPF_SEQ_PERF_EN
    chk("nom_perf", 32'(perf_cycles), 21);
`endif
    wait_cyc(b + 26);
`ifdef SPPF_SEQ_PERF_EN
    chk("nom_perf_hold", 32'(perf_cycles), 21);
`endif
    chk("nom_q_empty", 32'(exp_q.size()), 0);

    // Zero-latency engines: done in the start cycle must be ignored.
    b = cyc;
    cv1_q.push_back(b + 1); cv1_q.push_back(b + 2);
    for (int i = 3; i <= 8; i++) pool_q.push_back(b + i);
    cv2_q.push_back(b + 9); cv2_q.push_back(b + 10);
    exp_ev(b + 1,  1, 0, 0, 0, 0, 2'd0, 2'd0);
    exp_ev(b + 3,  0, 1, 0, 1, 0, 2'd0, 2'd0);
    exp_ev(b + 5,  0, 1, 0, 1, 0, 2'd1, 2'd1);
    exp_ev(b + 7,  0, 1, 0, 1, 0, 2'd2, 2'd2);
    exp_ev(b + 9,  0, 0, 1, 1, 0, 2'd0, 2'd3);
    exp_ev(b + 11, 0, 0, 0, 0, 1, 2'd0, 2'd0);
    start = 1'b1; tick(); start = 1'b0;
    wait_cyc(b + 14);
    chk("zl_q_empty", 32'(exp_q.size()), 0);

    // Timeout in POOL2, recovery via abort, err cleared by the next start.
    b = cyc;
    cv1_q.push_back(b + 4);
    pool_q.push_back(b + 8);
    exp_ev(b + 1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    exp_ev(b + 5, 0, 1, 0, 1, 0, 2'd0, 2'd0);
    exp_ev(b + 9, 0, 1, 0, 1, 0, 2'd1, 2'd1);
    start = 1'b1; tick(); start = 1'b0;
    wait_cyc(b + 16);
    chk("to_err_before", 32'(err), 0);
    chk("to_src_pool2", 32'(pool_src_sel), 1);
    wait_cyc(b + 17);
    chk("to_err_set", 32'(err), 1);
    chk("to_busy_err", 32'(busy), 1);
    chk("to_src_err", 32'(pool_src_sel), 0);
    wait_cyc(b + 22);
    chk("to_err_hold", 32'(err), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("to_busy_abort", 32'(busy), 0);
    chk("to_err_sticky", 32'(err), 1);
    exp_ev(b + 24, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("to_err_clear", 32'(err), 0);
    chk("to_busy_restart", 32'(busy), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("to_abort_cv1", 32'(busy), 0);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", 32'(busy), 0);
    wait_cyc(b + 30);
    chk("to_q_empty", 32'(exp_q.size()), 0);

    // Abort coinciding with pool_done in POOL1.
    b = cyc;
    cv1_q.push_back(b + 4);
    pool_q.push_back(b + 7);
    exp_ev(b + 1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    exp_ev(b + 5, 0, 1, 0, 1, 0, 2'd0, 2'd0);
    start = 1'b1; tick(); start = 1'b0;
    wait_cyc(b + 7);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_wr_done", 32'({cat_wr_en, done}), 0);
    wait_cyc(b + 12);
    chk("ab_q_empty", 32'(exp_q.size()), 0);

    // Synchronous reset while in CV2.
    b = cyc;
    cv1_q.push_back(b + 4);
    pool_q.push_back(b + 8); pool_q.push_back(b + 12); pool_q.push_back(b + 16);
    exp_ev(b + 1,  1, 0, 0, 0, 0, 2'd0, 2'd0);
    exp_ev(b + 5,  0, 1, 0, 1, 0, 2'd0, 2'd0);
    exp_ev(b + 9,  0, 1, 0, 1, 0, 2'd1, 2'd1);
    exp_ev(b + 13, 0, 1, 0, 1, 0, 2'd2, 2'd2);
    exp_ev(b + 17, 0, 0, 1, 1, 0, 2'd0, 2'd3);
    start = 1'b1; tick(); start = 1'b0;
    wait_cyc(b + 18);
    chk("rs_busy_cv2", 32'(busy), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rs_busy", 32'(busy), 0);
    chk("rs_outs", 32'({done, err, cv1_start, pool_start, cv2_start, cat_wr_en, cat_slot, pool_src_sel}), 0);
    wait_cyc(b + 24);
    chk("rs_q_empty", 32'(exp_q.size()), 0);

    // start held across done: back-to-back runs; start pulse in POOL3 ignored.
    b  = cyc;
    b2 = b + 21;
    plan_nominal(b);
    plan_nominal(b2);
    start = 1'b1;
    wait_cyc(b2);
    tick();
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 1);
    wait_cyc(b2 + 14);
    start = 1'b1; tick(); start = 1'b0;
    wait_cyc(b2 + 21);
    chk("b2b_done", 32'(done), 1);
    wait_cyc(b2 + 25);
    chk("b2b_idle", 32'(busy), 0);
    chk("b2b_q_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
